// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: mode encoding and index helpers.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Next channel index after idx, wrapping at n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Channel index reached k steps after base, wrapping modulo n.
    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned k,
                                             input int unsigned n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request search: first asserted request at or after ptr, wrapping at N-1.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (en) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = SELW'(wrap_add(32'(ptr), k, N));
                if (!gnt_valid && req[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage sustaining one word per cycle.
module stream_mux
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      select,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    logic            load_en;
    logic            grant_en;
    logic [SELW-1:0] ptr;

    logic            rr_valid;
    logic [SELW-1:0] rr_idx;
    logic            fix_valid;
    logic            gnt_valid;
    logic [SELW-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    // Output stage can accept a word when empty or draining this cycle; nothing is granted in reset.
    assign load_en  = !out_valid || out_ready;
    assign grant_en = load_en && rst_n;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .en        (grant_en),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    always_comb begin
        fix_valid = 1'b0;
        if (grant_en && (32'(select) < N)) begin
            fix_valid = in_valid[select];
        end
    end

    // Grant selection by mode; a mode/select change only steers this cycle's grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (mode_e'(mode) == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = fix_valid;
            gnt_idx   = select;
        end
    end

    always_comb begin
        in_ready = '0;
        if (gnt_valid) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; a granted channel always transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (gnt_valid) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_chan  <= gnt_idx;
                ptr       <= SELW'(wrap_inc(32'(gnt_idx), N));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (WIDTH=8, N=4) with hand-computed expectations.
module tb_stream_mux;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned SELW  = 2;

    logic                clk;
    logic                rst_n;
    logic                mode;
    logic [SELW-1:0]     select;
    logic [N-1:0]        in_valid;
    logic [N*WIDTH-1:0]  in_data;
    logic [N-1:0]        in_ready;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic [SELW-1:0]     out_chan;
    logic                out_ready;

    int unsigned n_checks;
    int unsigned n_pass;

    stream_mux #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .select    (select),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input int unsigned d,
                             input int unsigned c);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  d);
        check({tag, ".chan"},  32'(out_chan),  c);
    endtask

    initial begin
        int unsigned exp_chan;
        logic [3:0]  rr_seq [4];

        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        select    = '0;
        in_valid  = 4'b1111;
        in_data   = {8'd4, 8'd3, 8'd2, 8'd1};
        out_ready = 1'b1;

        // Reset: outputs cleared and no channel accepted while rst_n is low.
        tick();
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        tick();
        check_out("rst", 1'b0, 0, 0);
        check("rst.in_ready2", 32'(in_ready), 32'd0);

        // Fixed mode sweeps select 0..3 for 10 cycles each, latency 1.
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            select = SELW'(s);
            #1;
            check("fix.in_ready", 32'(in_ready), 32'(1) << s);
            for (int c = 0; c < 10; c++) begin
                tick();
                check_out("fix", 1'b1, s + 1, s);
            end
        end

        // Round-robin, all valid: channels 0,1,2,3,0,... every cycle (ptr=0 after select 3).
        mode = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_chan = c % 4;
            #1;
            check("rr.in_ready", 32'(in_ready), 32'(1) << exp_chan);
            tick();
            check_out("rr", 1'b1, exp_chan + 1, exp_chan);
        end

        // Round-robin with in_valid=1010: grants 1,3,1,3 only.
        in_valid = 4'b1010;
        rr_seq[0] = 4'b0010;
        rr_seq[1] = 4'b1000;
        rr_seq[2] = 4'b0010;
        rr_seq[3] = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            exp_chan = (c % 2 == 0) ? 1 : 3;
            #1;
            check("rr1010.in_ready", 32'(in_ready), 32'(rr_seq[c]));
            tick();
            check_out("rr1010", 1'b1, exp_chan + 1, exp_chan);
        end

        // Backpressure: held word (chan 3, data 4) stays stable, nothing accepted.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
            check_out("bp", 1'b1, 4, 3);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("bp.release", 1'b1, 1, 0);

        // Fixed select 2 with channel 2 idle: no transfer, output drains, data retained.
        mode     = 1'b0;
        select   = 2'd2;
        in_valid = 4'b1011;
        #1;
        check("idle.in_ready", 32'(in_ready), 32'd0);
        tick();
        check_out("idle.drain", 1'b0, 1, 0);
        tick();
        check_out("idle.hold", 1'b0, 1, 0);

        // Reset while holding a stalled word: word discarded, RR restarts at channel 0.
        mode     = 1'b1;
        in_valid = 4'b1111;
        tick();
        check_out("prerst", 1'b1, 2, 1);
        out_ready = 1'b0;
        tick();
        check_out("prerst.stall", 1'b1, 2, 1);
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready", 32'(in_ready), 32'd0);
        tick();
        check_out("midrst", 1'b0, 0, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("postrst.in_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("postrst", 1'b1, 1, 0);
        #1;
        check("postrst.in_ready2", 32'(in_ready), 32'b0010);
        tick();
        check_out("postrst2", 1'b1, 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
